// File: rtl/sw_debounce_irq_ctrl.sv
// Slide-switch sampler: 2-flop sync, shared-counter debounce, edge capture, IRQ.
// Define SW_DEBOUNCE_EN to build the debounce FSM; otherwise the synced level passes straight through.
module sw_debounce_irq_ctrl #(
    parameter int WIDTH           = 3,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("WIDTH must be 1..32");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
        $error("DEBOUNCE_CYCLES must be >= 2");
    end
    if ((64'd1 << CNT_W) < 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt
        $error("CNT_W too narrow for DEBOUNCE_CYCLES");
    end

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_nxt;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] clr;
    logic [31:0]      rd_nxt;
    logic             wr;
    logic             mask_we;
    logic             unused_wdata;

    assign wr           = chipselect && !write_n;
    assign mask_we      = wr && (address == 2'd2);
    assign clr          = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    assign unused_wdata = ^writedata;
    assign irq          = |(edgecapture & irqmask);

    // Two-flop synchroniser on the raw switch pins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

`ifdef SW_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        IDLE,
        COUNT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [WIDTH-1:0] candidate;
    logic [WIDTH-1:0] candidate_nxt;

    // Debounce next-state: any change restarts the shared counter
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        candidate_nxt = candidate;
        stable_nxt    = stable;
        edge_set      = '0;
        unique case (state)
            IDLE: begin
                if (sync2 != stable) begin
                    candidate_nxt = sync2;
                    cnt_nxt       = '0;
                    state_nxt     = COUNT;
                end
            end
            COUNT: begin
                if (sync2 == stable) begin
                    state_nxt = IDLE;
                end else if (sync2 != candidate) begin
                    candidate_nxt = sync2;
                    cnt_nxt       = '0;
                end else if (cnt == CNT_LAST) begin
                    stable_nxt = candidate;
                    edge_set   = stable ^ candidate;
                    state_nxt  = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Debounce FSM state, counter and candidate registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            candidate <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            candidate <= candidate_nxt;
        end
    end
`else
    // Without debounce the synced level is accepted every cycle
    always_comb begin
        stable_nxt = sync2;
        edge_set   = stable ^ sync2;
    end
`endif

    // Stable value, edge capture (set beats clear) and mask
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable      <= '0;
            edgecapture <= '0;
            irqmask     <= '0;
        end else begin
            stable      <= stable_nxt;
            edgecapture <= (edgecapture & ~clr) | edge_set;
            if (mask_we) begin
                irqmask <= writedata[WIDTH-1:0];
            end
        end
    end

    // Read mux, zero-extended to the bus width
    always_comb begin
        rd_nxt = '0;
        unique case (1'b1)
            address == 2'd0: rd_nxt[WIDTH-1:0] = stable;
            address == 2'd2: rd_nxt[WIDTH-1:0] = irqmask;
            address == 2'd3: rd_nxt[WIDTH-1:0] = edgecapture;
            default: rd_nxt = '0;
        endcase
    end

    // Registered read data, refreshed every cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_nxt;
        end
    end

endmodule

// File: tb/tb_sw_debounce_irq_ctrl.sv
// Directed bench for sw_debounce_irq_ctrl.
// WIDTH=3, DEBOUNCE_CYCLES=4; expectations adapt to SW_DEBOUNCE_EN.
module tb_sw_debounce_irq_ctrl;

    localparam int W   = 3;
    localparam int DEB = 4;
`ifdef SW_DEBOUNCE_EN
    localparam int          LAT       = DEB + 3;
    localparam logic [31:0] GLITCH_EC = 32'h0;
`else
    localparam int          LAT       = 3;
    localparam logic [31:0] GLITCH_EC = 32'h2;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic [1:0]   address;
    logic         chipselect;
    logic         write_n;
    logic [31:0]  writedata;
    logic [31:0]  readdata;
    logic [W-1:0] in_port;
    logic         irq;

    int n_checks = 0;
    int n_fail   = 0;

    sw_debounce_irq_ctrl #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .in_port(in_port),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a);
        address = a;
        tick();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '0;
        repeat (2) tick();
        chk("rst_readdata", readdata, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        reset_n = 1'b1;
        tick();
        rd(2'd0); chk("data_idle", readdata, 32'h0);
        rd(2'd1); chk("reserved_rd", readdata, 32'h0);
        rd(2'd3); chk("ec_idle", readdata, 32'h0);
        chk("irq_idle", 32'(irq), 32'h0);

        // 000 -> 101 and exact latency
        address = 2'd0;
        in_port = 3'b101;
        repeat (LAT) tick();
        chk("lat_hold", readdata, 32'h0);
        chk("irq_unmasked", 32'(irq), 32'h0);
        tick();
        chk("lat_data", readdata, 32'h5);
        rd(2'd3); chk("ec_101", readdata, 32'h5);
        wr(2'd1, 32'hffff_ffff);
        rd(2'd1); chk("reserved_wr", readdata, 32'h0);

        // mask, irq, write-1-clear
        wr(2'd2, 32'h1);
        chk("irq_on", 32'(irq), 32'h1);
        rd(2'd2); chk("mask_rd", readdata, 32'h1);
        wr(2'd3, 32'h1);
        rd(2'd3); chk("ec_clr1", readdata, 32'h4);
        chk("irq_clr1", 32'(irq), 32'h0);
        wr(2'd3, 32'h7);
        rd(2'd3); chk("ec_clr7", readdata, 32'h0);
        chk("irq_clr7", 32'(irq), 32'h0);

        // 3-cycle glitch on bit 1
        address = 2'd0;
        in_port = 3'b111;
        repeat (3) tick();
        in_port = 3'b101;
        repeat (10) tick();
        chk("glitch_data", readdata, 32'h5);
        rd(2'd3); chk("glitch_ec", readdata, GLITCH_EC);
        wr(2'd3, 32'h7);

        // bit 2 change at count 2 restarts the filter
        address = 2'd0;
        in_port = 3'b111;
        repeat (3) tick();
        in_port = 3'b011;
`ifdef SW_DEBOUNCE_EN
        repeat (7) tick();
        chk("restart_hold", readdata, 32'h5);
        tick();
`else
        repeat (8) tick();
`endif
        chk("restart_data", readdata, 32'h3);
        rd(2'd3); chk("restart_ec", readdata, 32'h6);
        chk("irq_mask1", 32'(irq), 32'h0);
        wr(2'd2, 32'h7);
        chk("irq_mask7", 32'(irq), 32'h1);

        // reset in the middle of a count
        address = 2'd0;
        in_port = 3'b000;
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        chk("midrst_rd", readdata, 32'h0);
        chk("midrst_irq", 32'(irq), 32'h0);
        in_port = 3'b001;
        tick();
        chk("midrst_rd2", readdata, 32'h0);
        reset_n = 1'b1;
        repeat (LAT) tick();
        chk("por_hold", readdata, 32'h0);
        tick();
        chk("por_edge", readdata, 32'h1);
        rd(2'd2); chk("por_mask", readdata, 32'h0);
        rd(2'd3); chk("por_ec", readdata, 32'h1);
        chk("por_irq", 32'(irq), 32'h0);

        // clear and capture on the same bit in the same cycle
        wr(2'd3, 32'h7);
        rd(2'd3); chk("coll_pre", readdata, 32'h0);
        in_port = 3'b000;
        repeat (LAT - 1) tick();
        wr(2'd3, 32'h1);
        rd(2'd3); chk("coll_setwins", readdata, 32'h1);
        rd(2'd0); chk("coll_data", readdata, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
